activation_unit_n: RTL and testbench

//   N-channel leaky integrate-and-fire activation stage: integrates per-channel signed input current into an

---
 rtl/snn_pkg.sv | 24 ++
 rtl/lif_neuron_channel.sv | 105 ++++++++++
 rtl/activation_unit_n.sv | 66 ++++++
 tb/tb_activation_unit_n.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared constants and saturation helper for the spiking activation stage
package snn_pkg;

   // Membrane handling after a spike
   localparam logic RST_ZERO = 1'b0;
   localparam logic RST_SUB  = 1'b1;

   // Clamp a signed value into the range of a w-bit two's complement number.
   // Callers size-cast the result down to w bits.
   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                      input int unsigned       w);
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (w - 1));
      if (x > max_v) begin
         return max_v;
      end else if (x < min_v) begin
         return min_v;
      end
      return x;
   endfunction

endpackage

// File: rtl/lif_neuron_channel.sv
// rtl/lif_neuron_channel.sv - one leaky integrate-and-fire neuron with refractory and spike counter
module lif_neuron_channel
   import snn_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int CNT_W    = 5,
   parameter int REFRAC_W = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_current,
   input  logic signed [DATA_W-1:0] threshold,
   input  logic [3:0]               leak_shift,
   input  logic [REFRAC_W-1:0]      refrac_steps,
   input  logic                     reset_mode,
   input  logic                     clear_counts,
   input  logic                     clear_state,
   output logic                     spike,
   output logic [CNT_W-1:0]         count,
   output logic                     count_sat
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic signed [DATA_W-1:0] v_q, v_d;
   logic [REFRAC_W-1:0]      r_q, r_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     sat_q, sat_d;
   logic                     spike_q, spike_d;

   logic signed [DATA_W-1:0] v_leak;
   logic signed [DATA_W:0]   sum_ext;
   logic signed [DATA_W-1:0] v_next;
   logic signed [DATA_W:0]   sub_ext;
   logic signed [DATA_W-1:0] v_sub;
   logic                     fire;

   // Integrate, leak, fire decision, refractory countdown and spike counting
   always_comb begin
      v_leak  = (leak_shift == 4'd0) ? v_q : v_q - (v_q >>> leak_shift);
      sum_ext = (DATA_W+1)'(v_leak) + (DATA_W+1)'(in_current);
      v_next  = DATA_W'(sat_signed(64'(sum_ext), DATA_W));
      fire    = (v_next >= threshold);
      sub_ext = (DATA_W+1)'(v_next) - (DATA_W+1)'(threshold);
      v_sub   = DATA_W'(sat_signed(64'(sub_ext), DATA_W));

      v_d     = v_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      sat_d   = sat_q;
      spike_d = 1'b0;

      if (in_valid) begin
         if (r_q != '0) begin
            // Refractory: input is dropped, potential frozen
            r_d = r_q - REFRAC_W'(1);
         end else if (fire) begin
            v_d     = (reset_mode == RST_SUB) ? v_sub : '0;
            r_d     = refrac_steps;
            spike_d = 1'b1;
         end else begin
            v_d = v_next;
         end
      end

      // State clear overrides any update in the same cycle, including the spike
      if (clear_state) begin
         v_d     = '0;
         r_d     = '0;
         spike_d = 1'b0;
      end

      // Counter clear still lets a coincident spike be counted
      if (clear_counts) begin
         cnt_d = spike_d ? CNT_W'(1) : '0;
         sat_d = 1'b0;
      end else if (spike_d && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
         sat_d = sat_q | (cnt_d == CNT_MAX);
      end
   end

   // Neuron state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
         spike_q <= 1'b0;
      end else begin
         v_q     <= v_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
         spike_q <= spike_d;
      end
   end

   assign spike     = spike_q;
   assign count     = cnt_q;
   assign count_sat = sat_q;

endmodule

// File: rtl/activation_unit_n.sv
// rtl/activation_unit_n.sv - N-channel LIF activation stage with spike counters
module activation_unit_n
   import snn_pkg::*;
#(
   parameter int N_CH     = 4,
   parameter int DATA_W   = 16,
   parameter int CNT_W    = 5,
   parameter int REFRAC_W = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [N_CH*DATA_W-1:0]   in_current,
   input  logic [N_CH*DATA_W-1:0]   threshold,
   input  logic [3:0]               leak_shift,
   input  logic [REFRAC_W-1:0]      refrac_steps,
   input  logic                     reset_mode,
   input  logic                     clear_counts,
   input  logic                     clear_state,
   output logic                     out_valid,
   output logic [N_CH-1:0]          out_spike,
   output logic [N_CH*CNT_W-1:0]    accumulated_spikes,
   output logic [N_CH-1:0]          count_sat
);

   logic out_valid_q, out_valid_d;

   // A timestep result appears one cycle after its input
   always_comb begin
      out_valid_d = in_valid;
   end

   // Output valid register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      lif_neuron_channel #(
         .DATA_W   (DATA_W),
         .CNT_W    (CNT_W),
         .REFRAC_W (REFRAC_W)
      ) u_ch (
         .clk          (clk),
         .rst          (rst),
         .in_valid     (in_valid),
         .in_current   (in_current[i*DATA_W +: DATA_W]),
         .threshold    (threshold[i*DATA_W +: DATA_W]),
         .leak_shift   (leak_shift),
         .refrac_steps (refrac_steps),
         .reset_mode   (reset_mode),
         .clear_counts (clear_counts),
         .clear_state  (clear_state),
         .spike        (out_spike[i]),
         .count        (accumulated_spikes[i*CNT_W +: CNT_W]),
         .count_sat    (count_sat[i])
      );
   end

endmodule

// File: tb/tb_activation_unit_n.sv
// tb/tb_activation_unit_n.sv - scoreboard bench for activation_unit_n
module tb_activation_unit_n;

   localparam int N_CH     = 4;
   localparam int DATA_W   = 16;
   localparam int CNT_W    = 5;
   localparam int REFRAC_W = 4;
   localparam int CMAX     = (1 << CNT_W) - 1;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   in_valid;
   logic [N_CH*DATA_W-1:0] in_current;
   logic [N_CH*DATA_W-1:0] threshold;
   logic [3:0]             leak_shift;
   logic [REFRAC_W-1:0]    refrac_steps;
   logic                   reset_mode;
   logic                   clear_counts;
   logic                   clear_state;
   logic                   out_valid;
   logic [N_CH-1:0]        out_spike;
   logic [N_CH*CNT_W-1:0]  accumulated_spikes;
   logic [N_CH-1:0]        count_sat;

   activation_unit_n #(
      .N_CH(N_CH), .DATA_W(DATA_W), .CNT_W(CNT_W), .REFRAC_W(REFRAC_W)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .in_valid           (in_valid),
      .in_current         (in_current),
      .threshold          (threshold),
      .leak_shift         (leak_shift),
      .refrac_steps       (refrac_steps),
      .reset_mode         (reset_mode),
      .clear_counts       (clear_counts),
      .clear_state        (clear_state),
      .out_valid          (out_valid),
      .out_spike          (out_spike),
      .accumulated_spikes (accumulated_spikes),
      .count_sat          (count_sat)
   );

   always #5 clk = ~clk;

   int vec_cnt = 0;
   int err_cnt = 0;

   // stimulus knobs
   int cur_a [N_CH];
   int thr_a [N_CH];
   int ls_a;
   int rs_a;
   int mode_a;

   // reference model state
   int m_v   [N_CH];
   int m_r   [N_CH];
   int m_cnt [N_CH];
   int m_sat [N_CH];

   logic [N_CH-1:0] sb_q [$];
   logic [N_CH-1:0] last_spike;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int clamp(input int x);
      if (x > 32767) return 32767;
      if (x < -32768) return -32768;
      return x;
   endfunction

   function automatic void model_reset();
      for (int c = 0; c < N_CH; c++) begin
         m_v[c] = 0; m_r[c] = 0; m_cnt[c] = 0; m_sat[c] = 0;
      end
   endfunction

   function automatic logic [N_CH-1:0] model_step(input logic v_in, input logic cc, input logic cs);
      logic [N_CH-1:0] spk;
      int vl, vn;
      spk = '0;
      for (int c = 0; c < N_CH; c++) begin
         if (v_in && !cs) begin
            if (m_r[c] > 0) begin
               m_r[c] = m_r[c] - 1;
            end else begin
               vl = (ls_a == 0) ? m_v[c] : m_v[c] - (m_v[c] >>> ls_a);
               vn = clamp(vl + cur_a[c]);
               if (vn >= thr_a[c]) begin
                  spk[c] = 1'b1;
                  m_v[c] = (mode_a != 0) ? clamp(vn - thr_a[c]) : 0;
                  m_r[c] = rs_a;
               end else begin
                  m_v[c] = vn;
               end
            end
         end
         if (cs) begin
            m_v[c] = 0;
            m_r[c] = 0;
         end
         if (cc) begin
            m_cnt[c] = spk[c] ? 1 : 0;
            m_sat[c] = 0;
         end else if (spk[c]) begin
            if (m_cnt[c] < CMAX) m_cnt[c] = m_cnt[c] + 1;
            if (m_cnt[c] == CMAX) m_sat[c] = 1;
         end
      end
      return spk;
   endfunction

   task automatic step(input logic v_in, input logic cc, input logic cs);
      logic [N_CH-1:0] exp_spk;
      for (int c = 0; c < N_CH; c++) begin
         in_current[c*DATA_W +: DATA_W] = DATA_W'(cur_a[c]);
         threshold[c*DATA_W +: DATA_W]  = DATA_W'(thr_a[c]);
      end
      leak_shift   = 4'(ls_a);
      refrac_steps = REFRAC_W'(rs_a);
      reset_mode   = (mode_a != 0);
      in_valid     = v_in;
      clear_counts = cc;
      clear_state  = cs;
      exp_spk = model_step(v_in, cc, cs);
      if (v_in) sb_q.push_back(exp_spk);
      @(posedge clk);
      #1;
      check("out_valid", 32'(out_valid), 32'(v_in));
      if (out_valid) begin
         if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
         end else begin
            check("out_spike", 32'(out_spike), 32'(sb_q.pop_front()));
         end
      end else begin
         check("idle_spike", 32'(out_spike), 32'd0);
      end
      for (int c = 0; c < N_CH; c++) begin
         check("count", 32'(accumulated_spikes[c*CNT_W +: CNT_W]), 32'(m_cnt[c]));
         check("count_sat", 32'(count_sat[c]), 32'(m_sat[c]));
      end
      last_spike = out_spike;
      in_valid     = 1'b0;
      clear_counts = 1'b0;
      clear_state  = 1'b0;
   endtask

   task automatic set_all(input int cur, input int thr);
      for (int c = 0; c < N_CH; c++) begin
         cur_a[c] = cur;
         thr_a[c] = thr;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_spike"}, 32'(out_spike), 32'd0);
      check({tag, "_counts"}, 32'(accumulated_spikes), 32'd0);
      check({tag, "_sat"}, 32'(count_sat), 32'd0);
   endtask

   initial begin
      logic [5:0] pat;
      rst = 1'b1;
      ls_a = 0; rs_a = 0; mode_a = 0;
      set_all(1000, -5);
      in_current   = '1;
      threshold    = '0;
      leak_shift   = '0;
      refrac_steps = '0;
      reset_mode   = 1'b0;
      in_valid     = 1'b1;
      clear_counts = 1'b0;
      clear_state  = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst_hold");
      in_valid = 1'b0;
      rst = 1'b0;

      // idle: nothing moves
      set_all(0, 32767);
      repeat (3) step(1'b0, 1'b0, 1'b0);

      // integrate 10 per step to threshold 32 on ch0, reset to zero
      cur_a[0] = 10; thr_a[0] = 32;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 1'b0);
         check("int4_spike", 32'(last_spike[0]), (i == 3) ? 32'd1 : 32'd0);
      end
      check("int4_count", 32'(accumulated_spikes[CNT_W-1:0]), 32'd1);

      // reset by subtraction: 40 -> v=8, then 8+30=38 -> v=6
      mode_a = 1; cur_a[0] = 40;
      step(1'b1, 1'b0, 1'b0);
      check("sub_first", 32'(last_spike[0]), 32'd1);
      cur_a[0] = 30;
      step(1'b1, 1'b0, 1'b0);
      check("sub_second", 32'(last_spike[0]), 32'd1);
      // residual 6 + 25 = 31 stays below 32
      cur_a[0] = 25;
      step(1'b1, 1'b0, 1'b0);
      check("sub_residual", 32'(last_spike[0]), 32'd0);

      // refractory of two steps
      mode_a = 0; rs_a = 2; cur_a[0] = 100;
      step(1'b0, 1'b1, 1'b1);
      pat = 6'b0;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b0, 1'b0);
         pat[i] = last_spike[0];
      end
      check("refrac_pattern", 32'(pat), 32'b001001);
      check("refrac_count", 32'(accumulated_spikes[CNT_W-1:0]), 32'd2);

      // leak halves the potential: 64 -> 32 -> 16 -> 8
      rs_a = 0;
      step(1'b0, 1'b0, 1'b1);
      cur_a[0] = 64; thr_a[0] = 32767;
      step(1'b1, 1'b0, 1'b0);
      ls_a = 1; cur_a[0] = 0;
      repeat (3) step(1'b1, 1'b0, 1'b0);
      ls_a = 0; thr_a[0] = 9;
      step(1'b1, 1'b0, 1'b0);
      check("leak_below", 32'(last_spike[0]), 32'd0);
      thr_a[0] = 8;
      step(1'b1, 1'b0, 1'b0);
      check("leak_at", 32'(last_spike[0]), 32'd1);

      // positive saturation: wrap would go negative and miss the threshold
      step(1'b0, 1'b0, 1'b1);
      thr_a[0] = 32767; cur_a[0] = 32000;
      step(1'b1, 1'b0, 1'b0);
      check("psat_below", 32'(last_spike[0]), 32'd0);
      cur_a[0] = 32767;
      step(1'b1, 1'b0, 1'b0);
      check("psat_fire", 32'(last_spike[0]), 32'd1);

      // negative saturation: wrap would reach 0 and falsely fire
      step(1'b0, 1'b0, 1'b1);
      thr_a[0] = -32767; cur_a[0] = -32768;
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      check("nsat_hold", 32'(last_spike[0]), 32'd0);

      // force 40 spikes on every channel: counters pin at max
      step(1'b0, 1'b1, 1'b1);
      set_all(0, -32768);
      repeat (40) step(1'b1, 1'b0, 1'b0);
      check("sat_count0", 32'(accumulated_spikes[CNT_W-1:0]), 32'(CMAX));
      check("sat_flags", 32'(count_sat), 32'hF);
      step(1'b1, 1'b1, 1'b0);
      check("clr_spike_count0", 32'(accumulated_spikes[CNT_W-1:0]), 32'd1);
      check("clr_spike_sat", 32'(count_sat), 32'd0);

      // clear_state with valid wins over the spike
      step(1'b1, 1'b0, 1'b1);
      check("cs_spike", 32'(last_spike), 32'd0);

      // random traffic
      for (int i = 0; i < 300; i++) begin
         for (int c = 0; c < N_CH; c++) begin
            cur_a[c] = $urandom_range(0, 6000) - 3000;
            thr_a[c] = $urandom_range(0, 8000) - 2000;
            if ($urandom_range(0, 15) == 0) cur_a[c] = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
         end
         ls_a   = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15);
         rs_a   = $urandom_range(0, 3);
         mode_a = $urandom_range(0, 1);
         step($urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
      end

      // asynchronous reset mid-run
      set_all(500, 100);
      step(1'b1, 1'b0, 1'b0);
      in_valid = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_async");
      model_reset();
      sb_q.delete();
      @(posedge clk);
      #1;
      check_reset_outputs("rst_mid");
      in_valid = 1'b0;
      rst = 1'b0;
      set_all(40, 100);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
      check("post_rst_spike", 32'(last_spike), 32'hF);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
